// File: rtl/r_return_router_pkg.sv
// Shared AXI read-return definitions: bus widths, router state/destination
// encodings and master tag values.
package r_return_router_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_DATA_BITS = 32;

  localparam int TAG_M0 = 0;
  localparam int TAG_M1 = 1;

  typedef enum logic [1:0] {IDLE, BUSY_S0, BUSY_S1} r_rt_state_e;
  typedef enum logic [1:0] {DEST_M0, DEST_M1, DEST_DROP} r_rt_dest_e;

  // tag arrives already shifted down to bit 0 and zero-extended
  function automatic r_rt_dest_e tagToDest(input logic [AXI_IDS_BITS-1:0] tag);
    if (tag == AXI_IDS_BITS'(TAG_M0))
      return DEST_M0;
    else if (tag == AXI_IDS_BITS'(TAG_M1))
      return DEST_M1;
    else
      return DEST_DROP;
  endfunction

endpackage

// File: rtl/r_return_router_arb2.sv
// Two-requester round-robin arbiter; priority bit moves to the requester that
// did not just finish, on each release pulse.
module r_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       relPulse,
  input  logic       relIdx,
  output logic [1:0] grant
);

  logic prio;

  always_ff @(posedge clk) begin
    if (rst)
      prio <= 1'b0;
    else if (relPulse)
      prio <= ~relIdx;
  end

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/r_return_router.sv
// AXI R-channel return router: locks one slave per burst, strips the master
// tag from the slave ID and steers beats to M0/M1, dropping unknown tags.
module r_return_router
  import r_return_router_pkg::*;
#(
  parameter int TAG_LSB = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [AXI_IDS_BITS-1:0]  RID_S0,
  input  logic [AXI_DATA_BITS-1:0] RDATA_S0,
  input  logic [1:0]               RRESP_S0,
  input  logic                     RLAST_S0,
  input  logic                     RVALID_S0,
  output logic                     RREADY_S0,
  input  logic [AXI_IDS_BITS-1:0]  RID_S1,
  input  logic [AXI_DATA_BITS-1:0] RDATA_S1,
  input  logic [1:0]               RRESP_S1,
  input  logic                     RLAST_S1,
  input  logic                     RVALID_S1,
  output logic                     RREADY_S1,
  output logic [AXI_ID_BITS-1:0]   RID_M0,
  output logic [AXI_DATA_BITS-1:0] RDATA_M0,
  output logic [1:0]               RRESP_M0,
  output logic                     RLAST_M0,
  output logic                     RVALID_M0,
  input  logic                     RREADY_M0,
  output logic [AXI_ID_BITS-1:0]   RID_M1,
  output logic [AXI_DATA_BITS-1:0] RDATA_M1,
  output logic [1:0]               RRESP_M1,
  output logic                     RLAST_M1,
  output logic                     RVALID_M1,
  input  logic                     RREADY_M1,
  output logic                     tag_err
);

  r_rt_state_e state;
  r_rt_dest_e  dest;
  logic        errSeen;

  logic                     busy, curS1;
  logic [1:0]               arbReq, arbGrant;
  logic [AXI_IDS_BITS-1:0]  grantId, tagExt;
  logic                     sValid, sLast, sReady, mReady, burstEnd;
  logic [AXI_ID_BITS-1:0]   sId;
  logic [AXI_DATA_BITS-1:0] sData;
  logic [1:0]               sResp;

  assign busy   = (state != IDLE);
  assign curS1  = (state == BUSY_S1);
  assign arbReq = busy ? 2'b00 : {RVALID_S1, RVALID_S0};

  r_rr_arb2 uArb (
    .clk      (ACLK),
    .rst      (ARESET),
    .req      (arbReq),
    .relPulse (burstEnd),
    .relIdx   (curS1),
    .grant    (arbGrant)
  );

  always_comb begin
    grantId = arbGrant[1] ? RID_S1 : RID_S0;
    tagExt  = grantId >> TAG_LSB;
  end

  always_comb begin
    sValid = curS1 ? RVALID_S1 : RVALID_S0;
    sLast  = curS1 ? RLAST_S1  : RLAST_S0;
    sId    = curS1 ? RID_S1[AXI_ID_BITS-1:0] : RID_S0[AXI_ID_BITS-1:0];
    sData  = curS1 ? RDATA_S1  : RDATA_S0;
    sResp  = curS1 ? RRESP_S1  : RRESP_S0;
    case (dest)
      DEST_M0: mReady = RREADY_M0;
      DEST_M1: mReady = RREADY_M1;
      default: mReady = 1'b1;
    endcase
    sReady   = busy & mReady;
    burstEnd = busy & sValid & sReady & sLast;
  end

  always_comb begin
    RREADY_S0 = (state == BUSY_S0) & sReady;
    RREADY_S1 = curS1 & sReady;
    RID_M0 = '0; RDATA_M0 = '0; RRESP_M0 = '0; RLAST_M0 = 1'b0; RVALID_M0 = 1'b0;
    RID_M1 = '0; RDATA_M1 = '0; RRESP_M1 = '0; RLAST_M1 = 1'b0; RVALID_M1 = 1'b0;
    if (busy && dest == DEST_M0) begin
      RID_M0 = sId; RDATA_M0 = sData; RRESP_M0 = sResp; RLAST_M0 = sLast; RVALID_M0 = sValid;
    end
    if (busy && dest == DEST_M1) begin
      RID_M1 = sId; RDATA_M1 = sData; RRESP_M1 = sResp; RLAST_M1 = sLast; RVALID_M1 = sValid;
    end
    tag_err = busy & (dest == DEST_DROP) & ~errSeen;
  end

  // errSeen limits the tag_err pulse to the first BUSY cycle of a dropped burst
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      dest    <= DEST_M0;
      errSeen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          errSeen <= 1'b0;
          if (arbGrant != 2'b00) begin
            state <= arbGrant[1] ? BUSY_S1 : BUSY_S0;
            dest  <= tagToDest(tagExt);
          end
        end
        default: begin
          errSeen <= 1'b1;
          if (burstEnd)
            state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r_return_router.sv
// Directed bench for r_return_router: burst routing, arbitration order,
// backpressure, tag drop and mid-burst reset.
module tb_r_return_router;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  RID_S0, RID_S1;
  logic [31:0] RDATA_S0, RDATA_S1;
  logic [1:0]  RRESP_S0, RRESP_S1;
  logic        RLAST_S0, RLAST_S1, RVALID_S0, RVALID_S1, RREADY_S0, RREADY_S1;
  logic [3:0]  RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic        tag_err;

  int nCmp = 0;
  int nErr = 0;

  always #5 ACLK = ~ACLK;

  r_return_router #(.TAG_LSB(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .RID_S0(RID_S0), .RDATA_S0(RDATA_S0), .RRESP_S0(RRESP_S0), .RLAST_S0(RLAST_S0),
    .RVALID_S0(RVALID_S0), .RREADY_S0(RREADY_S0),
    .RID_S1(RID_S1), .RDATA_S1(RDATA_S1), .RRESP_S1(RRESP_S1), .RLAST_S1(RLAST_S1),
    .RVALID_S1(RVALID_S1), .RREADY_S1(RREADY_S1),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .tag_err(tag_err)
  );

  task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nextCyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clearIn();
    RID_S0 = '0; RDATA_S0 = '0; RRESP_S0 = '0; RLAST_S0 = 1'b0; RVALID_S0 = 1'b0;
    RID_S1 = '0; RDATA_S1 = '0; RRESP_S1 = '0; RLAST_S1 = 1'b0; RVALID_S1 = 1'b0;
    RREADY_M0 = 1'b1;
    RREADY_M1 = 1'b1;
  endtask

  task automatic drvS0(input logic v, input logic [7:0] id, input logic [31:0] d, input logic l);
    RVALID_S0 = v; RID_S0 = id; RDATA_S0 = d; RLAST_S0 = l;
  endtask

  task automatic drvS1(input logic v, input logic [7:0] id, input logic [31:0] d, input logic l);
    RVALID_S1 = v; RID_S1 = id; RDATA_S1 = d; RLAST_S1 = l;
  endtask

  task automatic chkIdle(input string tag);
    chkVal({tag, " rreadyS0"}, RREADY_S0, 0);
    chkVal({tag, " rreadyS1"}, RREADY_S1, 0);
    chkVal({tag, " rvalidM0"}, RVALID_M0, 0);
    chkVal({tag, " rvalidM1"}, RVALID_M1, 0);
  endtask

  task automatic doReset();
    clearIn();
    ARESET = 1'b1;
    nextCyc();
    nextCyc();
    ARESET = 1'b0;
  endtask

  initial begin
    logic [31:0] dat [3];
    int idx;
    int errCnt;

    // reset state
    clearIn();
    ARESET = 1'b1;
    nextCyc();
    nextCyc();
    settle();
    chkIdle("rst");
    chkVal("rst tagErr", tag_err, 0);
    chkVal("rst rdataM0", RDATA_M0, 0);
    chkVal("rst ridM1", RID_M1, 0);
    ARESET = 1'b0;

    // 4-beat burst, S0 tag 1 ID 3 -> M1
    nextCyc();
    drvS0(1, 8'h13, 32'hA000_0000, 0);
    RRESP_S0 = 2'b10;
    settle();
    chkIdle("t1 grantCyc");
    for (int i = 0; i < 4; i++) begin
      nextCyc();
      drvS0(1, 8'h13, 32'hA000_0000 + i, i == 3);
      settle();
      chkVal("t1 rvalidM1", RVALID_M1, 1);
      chkVal("t1 ridM1", RID_M1, 32'h3);
      chkVal("t1 rdataM1", RDATA_M1, 32'hA000_0000 + i);
      chkVal("t1 rlastM1", RLAST_M1, (i == 3) ? 1 : 0);
      chkVal("t1 rrespM1", RRESP_M1, 2);
      chkVal("t1 rreadyS0", RREADY_S0, 1);
      chkVal("t1 rvalidM0", RVALID_M0, 0);
      chkVal("t1 rdataM0", RDATA_M0, 0);
    end
    nextCyc();
    clearIn();
    settle();
    chkIdle("t1 end");

    // contention after reset: S0 first, S1 after bubble, then S0 again
    doReset();
    nextCyc();
    drvS0(1, 8'h02, 32'hB000_0000, 0);
    drvS1(1, 8'h17, 32'hC000_0000, 1);
    settle();
    chkIdle("t2 grantCyc");
    nextCyc();
    settle();
    chkVal("t2 rreadyS0", RREADY_S0, 1);
    chkVal("t2 rvalidM0", RVALID_M0, 1);
    chkVal("t2 ridM0", RID_M0, 32'h2);
    chkVal("t2 rdataM0", RDATA_M0, 32'hB000_0000);
    chkVal("t2 rreadyS1 locked", RREADY_S1, 0);
    chkVal("t2 rvalidM1 locked", RVALID_M1, 0);
    nextCyc();
    drvS0(1, 8'h02, 32'hB000_0001, 1);
    settle();
    chkVal("t2 rlastM0", RLAST_M0, 1);
    chkVal("t2 rdataM0 b1", RDATA_M0, 32'hB000_0001);
    chkVal("t2 rreadyS1 locked2", RREADY_S1, 0);
    nextCyc();
    drvS0(0, 8'h00, 32'h0, 0);
    settle();
    chkVal("t2 bubble rreadyS1", RREADY_S1, 0);
    chkVal("t2 bubble rvalidM1", RVALID_M1, 0);
    nextCyc();
    settle();
    chkVal("t2 s1 rvalidM1", RVALID_M1, 1);
    chkVal("t2 s1 ridM1", RID_M1, 32'h7);
    chkVal("t2 s1 rdataM1", RDATA_M1, 32'hC000_0000);
    chkVal("t2 s1 rreadyS1", RREADY_S1, 1);
    nextCyc();
    drvS1(0, 8'h00, 32'h0, 0);
    settle();
    chkIdle("t2 idle");
    nextCyc();
    drvS0(1, 8'h01, 32'hB000_0002, 1);
    drvS1(1, 8'h18, 32'hC000_0001, 1);
    settle();
    nextCyc();
    settle();
    chkVal("t2 again rvalidM0", RVALID_M0, 1);
    chkVal("t2 again rdataM0", RDATA_M0, 32'hB000_0002);
    chkVal("t2 again rreadyS1", RREADY_S1, 0);
    nextCyc();
    drvS0(0, 8'h00, 32'h0, 0);
    settle();
    chkVal("t2 again bubble", RVALID_M1, 0);
    nextCyc();
    settle();
    chkVal("t2 again rvalidM1", RVALID_M1, 1);
    chkVal("t2 again ridM1", RID_M1, 32'h8);
    chkVal("t2 again rdataM1", RDATA_M1, 32'hC000_0001);
    nextCyc();
    clearIn();
    settle();
    chkIdle("t2 end");

    // backpressure on M0 over a 3-beat burst
    doReset();
    dat[0] = 32'h1111_0000;
    dat[1] = 32'h2222_0001;
    dat[2] = 32'h3333_0002;
    idx = 0;
    nextCyc();
    drvS0(1, 8'h05, dat[0], 0);
    settle();
    for (int k = 0; k < 5; k++) begin
      nextCyc();
      RREADY_M0 = (k % 2 == 0);
      drvS0(1, 8'h05, dat[idx], idx == 2);
      settle();
      chkVal("t3 rreadyS0 mirror", RREADY_S0, (k % 2 == 0) ? 1 : 0);
      chkVal("t3 rvalidM0", RVALID_M0, 1);
      chkVal("t3 ridM0", RID_M0, 32'h5);
      chkVal("t3 rdataM0 order", RDATA_M0, dat[idx]);
      if (RREADY_S0 && RVALID_S0 && idx < 3)
        idx++;
    end
    nextCyc();
    clearIn();
    settle();
    chkVal("t3 beats", idx, 3);
    chkIdle("t3 end");

    // unknown tag 5: dropped, flagged once; tag change mid-burst ignored
    doReset();
    errCnt = 0;
    nextCyc();
    drvS1(1, 8'h52, 32'hD000_0000, 0);
    settle();
    chkVal("t4 grant tagErr", tag_err, 0);
    chkVal("t4 grant rreadyS1", RREADY_S1, 0);
    for (int i = 0; i < 2; i++) begin
      nextCyc();
      drvS1(1, (i == 0) ? 8'h52 : 8'h12, 32'hD000_0000 + i, i == 1);
      settle();
      chkVal("t4 rreadyS1", RREADY_S1, 1);
      chkVal("t4 rvalidM0", RVALID_M0, 0);
      chkVal("t4 rvalidM1", RVALID_M1, 0);
      chkVal("t4 tagErr", tag_err, (i == 0) ? 1 : 0);
      if (tag_err)
        errCnt++;
    end
    nextCyc();
    clearIn();
    settle();
    if (tag_err)
      errCnt++;
    chkVal("t4 tagErr pulses", errCnt, 1);
    chkIdle("t4 end");

    // reset on beat 2 of a 4-beat burst, then a fresh S1 burst
    doReset();
    nextCyc();
    drvS0(1, 8'h09, 32'hE000_0000, 0);
    settle();
    nextCyc();
    settle();
    chkVal("t5 b0 rdataM0", RDATA_M0, 32'hE000_0000);
    nextCyc();
    drvS0(1, 8'h09, 32'hE000_0001, 0);
    ARESET = 1'b1;
    settle();
    chkVal("t5 b1 rvalidM0", RVALID_M0, 1);
    chkVal("t5 b1 rdataM0", RDATA_M0, 32'hE000_0001);
    nextCyc();
    ARESET = 1'b0;
    clearIn();
    settle();
    chkIdle("t5 post");
    chkVal("t5 post rdataM0", RDATA_M0, 0);
    chkVal("t5 post ridM0", RID_M0, 0);
    chkVal("t5 post rlastM0", RLAST_M0, 0);
    chkVal("t5 post tagErr", tag_err, 0);
    nextCyc();
    drvS1(1, 8'h1A, 32'hF000_0000, 1);
    settle();
    chkIdle("t5 grantCyc");
    nextCyc();
    settle();
    chkVal("t5 s1 rvalidM1", RVALID_M1, 1);
    chkVal("t5 s1 ridM1", RID_M1, 32'hA);
    chkVal("t5 s1 rdataM1", RDATA_M1, 32'hF000_0000);
    chkVal("t5 s1 rreadyS1", RREADY_S1, 1);
    nextCyc();
    clearIn();
    settle();
    chkIdle("t5 end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
